// File: rtl/life_timer_pkg.sv
// Shared types and constants for the Game of Life generation scheduler.
// Holds the state encoding and the default one-second tick period.
package life_timer_pkg;

  localparam int TICK_W = 24;
  localparam int GEN_W  = 16;

  localparam logic [TICK_W-1:0] ONE_SECOND_12MHZ = 24'd12_000_000;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    COUNT_REQ,
    ONESHOT_REQ
  } sched_state_t;

endpackage

// File: rtl/life_step_scheduler_period_counter.sv
// Programmable-period tick counter for the generation scheduler.
// Wraps to zero on the terminal count; clr has priority over en.
module period_counter
  import life_timer_pkg::*;
#(
  parameter int TICK_W = life_timer_pkg::TICK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [TICK_W-1:0] period_q,
  output logic [TICK_W-1:0] tick_cnt,
  output logic              terminal
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;
  logic [TICK_W-1:0] cnt_inc;
  logic              hit;

  assign cnt_inc  = cnt_q + TICK_W'(1);
  assign hit      = (cnt_q == period_q - TICK_W'(1));
  assign terminal = en & hit;
  assign tick_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = terminal ? '0 : cnt_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/life_step_scheduler.sv
// Paces Game of Life generations: run/pause/single-step with a
// req/ack handshake to the grid engine and a sticky overrun flag.
module life_step_scheduler
  import life_timer_pkg::*;
#(
  parameter int TICK_W = life_timer_pkg::TICK_W,
  parameter int GEN_W  = life_timer_pkg::GEN_W,
  parameter int CLK_HZ =
    int'(life_timer_pkg::ONE_SECOND_12MHZ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_once,
  input  logic [TICK_W-1:0] period,
  input  logic              clr_overrun,
  input  logic              step_ack,
  output logic              step_req,
  output logic              busy,
  output logic [GEN_W-1:0]  gen_count,
  output logic              overrun
);

  if ($clog2(CLK_HZ + 1) > TICK_W) begin : g_clk_chk
    $error("one-second period does not fit TICK_W");
  end

  sched_state_t      state_q, state_d;
  logic [TICK_W-1:0] period_q, period_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;

  logic              xfer;
  logic              cnt_en;
  logic              cnt_clr;
  logic              terminal;
  logic [TICK_W-1:0] tick_cnt;

  period_counter #(
    .TICK_W   (TICK_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .period_q (period_q),
    .tick_cnt (tick_cnt),
    .terminal (terminal)
  );

  assign xfer = req_q & step_ack;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    ovr_d    = ovr_q & ~clr_overrun;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d  = COUNT;
          period_d = (period == '0) ? TICK_W'(1) : period;
        end else if (step_once) begin
          state_d = ONESHOT_REQ;
        end
      end
      COUNT: begin
        if (!run)
          state_d = IDLE;
        else if (terminal)
          state_d = COUNT_REQ;
      end
      COUNT_REQ: begin
        // A tick with the grid still busy is dropped, not queued
        if (terminal && !xfer)
          ovr_d = 1'b1;
        if (!run)
          state_d = xfer ? IDLE : ONESHOT_REQ;
        else if (xfer)
          state_d = terminal ? COUNT_REQ : COUNT;
      end
      ONESHOT_REQ: begin
        if (xfer)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gen_d   = xfer ? gen_q + GEN_W'(1) : gen_q;
    req_d   = (state_d == COUNT_REQ) ||
              (state_d == ONESHOT_REQ);
    busy_d  = (state_d != IDLE);
    cnt_en  = (state_q == COUNT) ||
              (state_q == COUNT_REQ);
    cnt_clr = !((state_d == COUNT) ||
                (state_d == COUNT_REQ));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      gen_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      gen_q    <= gen_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign step_req  = req_q;
  assign busy      = busy_q;
  assign gen_count = gen_q;
  assign overrun   = ovr_q;

endmodule

// File: doc/life_step_scheduler.md
Name: life_step_scheduler

Overview:
- Paces Game of Life generation updates from the 12 MHz system clock.
- Contains a programmable-period tick counter, which generalises the fixed 1-second timer.
- Issues one req/ack handshake per generation to the grid-update engine and supports run, pause and single-step.
- Sits between the user-control logic (buttons/switches) and the life grid datapath.

Parameters:
- TICK_W, 24, width of the period and tick counter.
- GEN_W, 16, width of the generation counter.
- CLK_HZ, 12_000_000, clock frequency; also the default one-second period constant.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- run  input  1  level; 1 = free-running generations, 0 = paused.
- step_once  input  1  single-cycle pulse; request one generation while paused.
- period  input  TICK_W  clock cycles per generation; 0 is treated as 1.
- clr_overrun  input  1  single-cycle pulse; clears overrun.
- step_ack  input  1  grid engine acknowledges the current step_req.
- step_req  output  1  request for the grid to compute one generation.
- busy  output  1  1 whenever state != IDLE.
- gen_count  output  GEN_W  completed generations (number of acked requests).
- overrun  output  1  sticky; a tick expired while step_req was still outstanding.

Behaviour:
- Reset (rst=0, async): state=IDLE, tick_cnt=0, period_q=0, step_req=0, busy=0, gen_count=0, overrun=0. All outputs are registered.
- period_q is latched from period (0 mapped to 1) on every entry to COUNT. Changes to period during COUNT take effect only after the next pause/run cycle.
- Terminal tick: asserted in a cycle where counting is active and tick_cnt == period_q-1. On that edge tick_cnt returns to 0; otherwise it increments.
- Handshake:
  - step_req is a registered level.
  - A transfer occurs on any cycle with step_req=1 and step_ack=1.
  - step_req deasserts on the clock edge after the transfer.
  - gen_count increments on the transfer edge and wraps from 2^GEN_W-1 to 0.
  - step_ack while step_req=0 is ignored.
- States:
  - IDLE:
    - No counting.
    - run=1 -> COUNT: tick_cnt=0, latch period_q.
    - Else step_once=1 -> ONESHOT_REQ: step_req=1.
    - run wins if run and step_once are both asserted.
  - COUNT:
    - Counting active; step_req=0.
    - run=0 -> IDLE, tick_cnt cleared.
    - Else terminal tick -> COUNT_REQ, step_req=1.
    - step_once is ignored.
  - COUNT_REQ:
    - Counting continues; step_req=1.
    - Transfer and run=1 -> COUNT.
    - run=0 (with or without transfer) -> ONESHOT_REQ if no transfer, IDLE if transfer; tick_cnt cleared in both cases.
    - Terminal tick with no transfer in the same cycle -> overrun set to 1. The tick is dropped, not queued, and the state is unchanged.
    - Terminal tick in the same cycle as a transfer -> no overrun; go directly to COUNT_REQ with step_req held at 1 (a new request).
  - ONESHOT_REQ:
    - No counting; step_req=1.
    - Transfer -> IDLE.
    - run and step_once are ignored until the transfer.
- Timing:
  - step_req rises exactly period_q cycles after the first COUNT cycle.
  - With step_ack tied high, requests are spaced exactly period_q cycles apart.
- period_q=1: terminal tick every counting cycle. Ack must be combinational-same-cycle to avoid overrun; otherwise overrun sets as specified.
- clr_overrun clears overrun at the next edge. If it coincides with a new overrun event, set wins.
- Reset mid-handshake: step_req drops immediately (async) and the pending generation is abandoned.

Decomposition:
- Package life_timer_pkg holds:
  - Enum sched_state_t {IDLE, COUNT, COUNT_REQ, ONESHOT_REQ}.
  - Localparams TICK_W=24 and GEN_W=16.
  - ONE_SECOND_12MHZ = 24'd12_000_000.
- Sub-module period_counter:
  - Ports: clk, rst, en, clr, period_q.
  - Outputs: tick_cnt, terminal.
  - Adder-based incrementer plus equality compare; the scheduler instantiates one.

Test Plan:
- Reset mid-COUNT_REQ (period=3, no ack) -> step_req, busy, gen_count and overrun all go to 0 immediately without waiting for clk; after release, state is IDLE.
- period=4, step_ack tied 1, run raised -> step_req pulses for 1 cycle, first at 4 cycles after COUNT entry, then every 4 cycles. gen_count=3 after 12 counting cycles; overrun stays 0.
- run=0, step_once pulse, ack delayed 5 cycles -> step_req high for 5 cycles then low. gen_count=1, state returns to IDLE, tick_cnt remains 0.
- period=3, run=1, ack withheld 8 cycles -> overrun=1 at the second terminal tick and remains 1 after the ack. gen_count=1; clr_overrun -> overrun=0.
- run dropped during COUNT_REQ, ack 2 cycles later -> step_req held until the ack; then IDLE, gen_count+1, no further step_req.
- period=0, run=1, ack tied 1 -> behaves as period=1, with step_req asserted continuously as back-to-back requests. gen_count wraps 0xFFFF->0x0000 when preloaded near the limit via a forced run of 65536 steps.
